// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_monitor
//  Description : Passive checker for the VGA HS/VS pair at the connector.
//                Measures line length, hsync width, lines per frame and
//                vsync width in system clocks and compares them against the
//                configured timing. Reports lock, last measurements, a
//                per-frame strobe and a saturating error count.
//  Ports       : clk         - system clock
//                reset       - asynchronous active-low reset
//                hs_in       - observed hsync (active-low)
//                vs_in       - observed vsync (active-low)
//                locked      - timing matched for LOCK_FRAMES frames
//                line_clks   - clocks between the last two hsync falls
//                hs_width    - clocks hsync was low in the last line
//                frame_lines - hsync falls counted in the last judged frame
//                frame_done  - one-cycle strobe after each frame compare
//                err_count   - saturating count of timing errors
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_monitor #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        locked,
    output logic [11:0] line_clks,
    output logic [11:0] hs_width,
    output logic [9:0]  frame_lines,
    output logic        frame_done,
    output logic [7:0]  err_count
);

    localparam logic [11:0] c_line_clks = 12'(H_TOTAL * CLK_PER_PIX);
    localparam logic [11:0] c_hs_clks   = 12'(H_SYNC * CLK_PER_PIX);
    localparam logic [9:0]  c_v_total   = 10'(V_TOTAL);
    localparam logic [9:0]  c_v_sync    = 10'(V_SYNC);
    localparam logic [7:0]  c_lock_frm  = 8'(LOCK_FRAMES);
    localparam logic [11:0] c_clk_max   = 12'hFFF;
    localparam logic [9:0]  c_line_max  = 10'h3FF;
    localparam logic [7:0]  c_err_max   = 8'hFF;

    localparam logic [1:0] c_st_search  = 2'd0;
    localparam logic [1:0] c_st_acquire = 2'd1;
    localparam logic [1:0] c_st_locked  = 2'd2;

    // Synchronisers idle high so a reset never fabricates a falling edge.
    logic r_hs_meta, r_hs_sync, r_hs_prev;
    logic r_vs_meta, r_vs_sync, r_vs_prev;

    logic [11:0] r_line_cnt, r_hs_low_cnt, r_line_clks, r_hs_width;
    logic [9:0]  r_lines, r_vlines, r_frame_lines;
    logic        r_frame_bad, r_locked, r_frame_done;
    logic [7:0]  r_err_count, r_good_cnt;
    logic [1:0]  r_state;

    logic        w_hs_fall, w_hs_rise, w_vs_fall;
    logic [11:0] w_line_len;
    logic        w_line_err, w_width_err, w_frame_bad, w_good;
    logic [9:0]  w_lines, w_vlines;
    logic        w_line_to, w_frame_to;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_good_nxt;
    logic        w_locked_nxt, w_err_inc, w_done_nxt;

    assign w_hs_fall = r_hs_prev & ~r_hs_sync;
    assign w_hs_rise = ~r_hs_prev & r_hs_sync;
    assign w_vs_fall = r_vs_prev & ~r_vs_sync;

    // Length of the line that ends on this hsync fall (counter + this clock).
    assign w_line_len  = (r_line_cnt == c_clk_max) ? c_clk_max : r_line_cnt + 12'd1;
    assign w_line_err  = w_hs_fall & (w_line_len != c_line_clks);
    assign w_width_err = w_hs_rise & (r_hs_low_cnt != c_hs_clks);
    assign w_frame_bad = r_frame_bad | w_line_err | w_width_err;

    // An hsync fall coinciding with the vsync fall belongs to the ending frame,
    // so the compare looks at the counts including this cycle's edge.
    assign w_lines  = (w_hs_fall && r_lines != c_line_max) ? r_lines + 10'd1 : r_lines;
    assign w_vlines = (w_hs_fall && !r_vs_sync && r_vlines != c_line_max)
                      ? r_vlines + 10'd1 : r_vlines;
    assign w_good   = (w_lines == c_v_total) && (w_vlines == c_v_sync) && !w_frame_bad;

    assign w_line_to  = (r_line_cnt == c_clk_max);
    assign w_frame_to = (r_lines == c_line_max);

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good_cnt;
        w_locked_nxt = r_locked;
        w_err_inc    = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_st_search: begin
                // The partial frame seen before the first vsync is never judged.
                if (w_vs_fall) begin
                    w_state_nxt = c_st_acquire;
                    w_good_nxt  = 8'd0;
                end
            end
            c_st_acquire, c_st_locked: begin
                if (w_line_to || w_frame_to) begin
                    // Counters only reach their ceiling when sync has stalled;
                    // SEARCH ignores it, so this counts once per stall.
                    w_err_inc    = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_good_nxt   = 8'd0;
                    w_state_nxt  = c_st_search;
                end else if (w_vs_fall) begin
                    w_done_nxt = 1'b1;
                    if (!w_good) begin
                        w_err_inc    = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_good_nxt   = 8'd0;
                        w_state_nxt  = c_st_acquire;
                    end else if (r_state == c_st_acquire) begin
                        w_good_nxt = r_good_cnt + 8'd1;
                        if (w_good_nxt == c_lock_frm) begin
                            w_state_nxt  = c_st_locked;
                            w_locked_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt  = c_st_search;
                w_locked_nxt = 1'b0;
                w_good_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs_meta     <= 1'b1;
            r_hs_sync     <= 1'b1;
            r_hs_prev     <= 1'b1;
            r_vs_meta     <= 1'b1;
            r_vs_sync     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_line_cnt    <= '0;
            r_hs_low_cnt  <= '0;
            r_line_clks   <= '0;
            r_hs_width    <= '0;
            r_lines       <= '0;
            r_vlines      <= '0;
            r_frame_lines <= '0;
            r_frame_bad   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_count   <= '0;
            r_good_cnt    <= '0;
            r_state       <= c_st_search;
        end else begin
            r_hs_meta <= hs_in;
            r_hs_sync <= r_hs_meta;
            r_hs_prev <= r_hs_sync;
            r_vs_meta <= vs_in;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;

            if (w_hs_fall)
                r_line_cnt <= '0;
            else if (!w_line_to)
                r_line_cnt <= r_line_cnt + 12'd1;
            if (w_hs_fall)
                r_line_clks <= w_line_len;

            // The fall cycle is the first low clock of the pulse.
            if (w_hs_fall)
                r_hs_low_cnt <= 12'd1;
            else if (!r_hs_sync && r_hs_low_cnt != c_clk_max)
                r_hs_low_cnt <= r_hs_low_cnt + 12'd1;
            if (w_hs_rise)
                r_hs_width <= r_hs_low_cnt;

            if (w_vs_fall) begin
                r_lines     <= '0;
                r_vlines    <= '0;
                r_frame_bad <= 1'b0;
            end else begin
                r_lines     <= w_lines;
                r_vlines    <= w_vlines;
                r_frame_bad <= w_frame_bad;
            end
            if (w_done_nxt)
                r_frame_lines <= w_lines;

            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_locked     <= w_locked_nxt;
            r_frame_done <= w_done_nxt;
            if (w_err_inc && r_err_count != c_err_max)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign locked      = r_locked;
    assign line_clks   = r_line_clks;
    assign hs_width    = r_hs_width;
    assign frame_lines = r_frame_lines;
    assign frame_done  = r_frame_done;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_monitor
//  Description : Directed self-checking bench for vga_sync_monitor. Timing is
//                scaled down (20-clk lines, 4-clk hsync, 8-line frames,
//                2-line vsync) so that hundreds of frames stay short; the
//                12/10/8-bit saturation limits are unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_monitor;

    localparam int LINE_CLKS = 20;   // H_TOTAL 10 * CLK_PER_PIX 2
    localparam int HSW_CLKS  = 4;    // H_SYNC 2 * CLK_PER_PIX 2
    localparam int FRM_LINES = 8;
    localparam int VS_OFS    = 10;   // vsync edges placed mid-line, after hsync

    logic        clk;
    logic        reset;
    logic        hs_in;
    logic        vs_in;
    logic        locked;
    logic [11:0] line_clks;
    logic [11:0] hs_width;
    logic [9:0]  frame_lines;
    logic        frame_done;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    vga_sync_monitor #(
        .CLK_PER_PIX(2), .H_TOTAL(10), .H_SYNC(2),
        .V_TOTAL(FRM_LINES), .V_SYNC(2), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .locked(locked), .line_clks(line_clks), .hs_width(hs_width),
        .frame_lines(frame_lines), .frame_done(frame_done), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic send_line(input int len, input bit vs_fall, input bit vs_rise);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hs_in = (i < HSW_CLKS) ? 1'b0 : 1'b1;
            if (i == VS_OFS && vs_fall) vs_in = 1'b0;
            if (i == VS_OFS && vs_rise) vs_in = 1'b1;
        end
    endtask

    task automatic send_frame(input int nlines, input int bad_idx, input int bad_len);
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_idx) ? bad_len : LINE_CLKS, l == 0, l == 2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int d0;
        reset = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        idle(5);
        n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL rst_err: got %0d expected 0", err_count); else n_pass++;
        reset = 1'b1;
        d0 = done_cnt;
        idle(10000);
        n_checks++; if (locked !== 1'b0) $display("FAIL idle_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL idle_err: got %0d expected 0", err_count); else n_pass++;
        n_checks++; if (line_clks !== 12'd0) $display("FAIL idle_line_clks: got %0d expected 0", line_clks); else n_pass++;
        n_checks++; if (hs_width !== 12'd0) $display("FAIL idle_hs_width: got %0d expected 0", hs_width); else n_pass++;
        n_checks++; if (frame_lines !== 10'd0) $display("FAIL idle_frame_lines: got %0d expected 0", frame_lines); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL idle_done: got %0d expected 0", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_ideal();
        int d0;
        d0 = done_cnt;
        send_frame(FRM_LINES, -1, 0);    // first vsync: SEARCH -> ACQUIRE
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL ideal_no_done_first: got %0d expected 0", done_cnt - d0); else n_pass++;
        send_frame(FRM_LINES, -1, 0);    // judges frame 0: one good frame
        n_checks++; if (locked !== 1'b0) $display("FAIL ideal_locked_early: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL ideal_done1: got %0d expected 1", done_cnt - d0); else n_pass++;
        send_frame(FRM_LINES, -1, 0);    // second good frame -> locked
        n_checks++; if (locked !== 1'b1) $display("FAIL ideal_locked: got %0d expected 1", locked); else n_pass++;
        n_checks++; if (line_clks !== 12'd20) $display("FAIL ideal_line_clks: got %0d expected 20", line_clks); else n_pass++;
        n_checks++; if (hs_width !== 12'd4) $display("FAIL ideal_hs_width: got %0d expected 4", hs_width); else n_pass++;
        n_checks++; if (frame_lines !== 10'd8) $display("FAIL ideal_frame_lines: got %0d expected 8", frame_lines); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL ideal_err: got %0d expected 0", err_count); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 2) $display("FAIL ideal_done2: got %0d expected 2", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_bad_line();
        send_frame(FRM_LINES, 6, 24);    // line 6 is 24 clks, measured at line 7
        n_checks++; if (line_clks !== 12'd24) $display("FAIL bad_line_clks: got %0d expected 24", line_clks); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL bad_locked_before: got %0d expected 1", locked); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL bad_err_before: got %0d expected 0", err_count); else n_pass++;
        send_frame(FRM_LINES, -1, 0);    // judges the frame with the long line
        n_checks++; if (err_count !== 8'd1) $display("FAIL bad_err: got %0d expected 1", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL bad_unlock: got %0d expected 0", locked); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (locked !== 1'b0) $display("FAIL bad_relock_early: got %0d expected 0", locked); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (locked !== 1'b1) $display("FAIL bad_relock: got %0d expected 1", locked); else n_pass++;
        n_checks++; if (err_count !== 8'd1) $display("FAIL bad_err_hold: got %0d expected 1", err_count); else n_pass++;
    endtask

    task automatic test_stall();
        int d0;
        send_frame(3, -1, 0);            // partial locked frame, then hsync stops
        idle(4000);
        n_checks++; if (err_count !== 8'd1) $display("FAIL stall_err_early: got %0d expected 1", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL stall_locked_early: got %0d expected 1", locked); else n_pass++;
        idle(1000);
        n_checks++; if (err_count !== 8'd2) $display("FAIL stall_err: got %0d expected 2", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL stall_unlock: got %0d expected 0", locked); else n_pass++;
        d0 = done_cnt;
        send_frame(FRM_LINES, -1, 0);    // back in SEARCH: this vsync is not judged
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL stall_search_done: got %0d expected 0", done_cnt - d0); else n_pass++;
        n_checks++; if (err_count !== 8'd2) $display("FAIL stall_err_once: got %0d expected 2", err_count); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (locked !== 1'b0) $display("FAIL stall_relock_early: got %0d expected 0", locked); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (locked !== 1'b1) $display("FAIL stall_relock: got %0d expected 1", locked); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 2) $display("FAIL stall_done: got %0d expected 2", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        send_frame(4, -1, 0);            // stop partway through a locked frame
        reset = 1'b0;
        idle(2);
        n_checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL mid_err: got %0d expected 0", err_count); else n_pass++;
        n_checks++; if (line_clks !== 12'd0) $display("FAIL mid_line_clks: got %0d expected 0", line_clks); else n_pass++;
        n_checks++; if (frame_lines !== 10'd0) $display("FAIL mid_frame_lines: got %0d expected 0", frame_lines); else n_pass++;
        idle(3);
        reset = 1'b1;
        d0 = done_cnt;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL mid_first_done: got %0d expected 0", done_cnt - d0); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL mid_done1: got %0d expected 1", done_cnt - d0); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL mid_locked_early: got %0d expected 0", locked); else n_pass++;
        send_frame(FRM_LINES, -1, 0);
        n_checks++; if (locked !== 1'b1) $display("FAIL mid_relock: got %0d expected 1", locked); else n_pass++;
        n_checks++; if (frame_lines !== 10'd8) $display("FAIL mid_frame_lines_after: got %0d expected 8", frame_lines); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL mid_err_after: got %0d expected 0", err_count); else n_pass++;
    endtask

    task automatic test_wrong_len();
        int d0;
        d0 = done_cnt;
        // First short frame's vsync judges the preceding good frame; every
        // later vsync judges a 7-line frame.
        for (int k = 0; k < 3; k++) send_frame(FRM_LINES - 1, -1, 0);
        n_checks++; if (err_count !== 8'd2) $display("FAIL wrong_err3: got %0d expected 2", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL wrong_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (frame_lines !== 10'd7) $display("FAIL wrong_frame_lines: got %0d expected 7", frame_lines); else n_pass++;
        for (int k = 3; k < 255; k++) send_frame(FRM_LINES - 1, -1, 0);
        n_checks++; if (err_count !== 8'd254) $display("FAIL wrong_err254: got %0d expected 254", err_count); else n_pass++;
        send_frame(FRM_LINES - 1, -1, 0);
        n_checks++; if (err_count !== 8'd255) $display("FAIL wrong_err255: got %0d expected 255", err_count); else n_pass++;
        for (int k = 256; k < 260; k++) send_frame(FRM_LINES - 1, -1, 0);
        n_checks++; if (err_count !== 8'd255) $display("FAIL wrong_err_sat: got %0d expected 255", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL wrong_locked_end: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 260) $display("FAIL wrong_done: got %0d expected 260", done_cnt - d0); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        hs_in = 1'b1;
        vs_in = 1'b1;
        test_reset();
        test_ideal();
        test_bad_line();
        test_stall();
        test_reset_mid();
        test_wrong_len();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
